fifo_rd_ctrl: RTL

//   Read-side controller of the async FIFO; the counterpart of the write-side

---
 rtl/fifo_rd_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: write-pointer synchroniser, read pointer,
// empty/level flags and a one-word prefetch register with valid/ready handshake.
module fifo_rd_ctrl #(
    parameter int unsigned PTR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                   r_clk,
    input  logic                   r_rst,
    input  logic [PTR_WIDTH-1:0]   w_gray_ptr,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [PTR_WIDTH-2:0]   r_addr,
    output logic [PTR_WIDTH-1:0]   gray_r_ptr,
    output logic                   r_empty,
    output logic [PTR_WIDTH-1:0]   r_level,
    output logic                   r_almost_empty,
    output logic [DATA_WIDTH-1:0]  r_data,
    output logic                   r_valid,
    input  logic                   r_ready
);

    logic [PTR_WIDTH-1:0] r_ptr;
    logic [PTR_WIDTH-1:0] rq1;
    logic [PTR_WIDTH-1:0] rq2;
    logic [PTR_WIDTH-1:0] wq_bin;
    logic [PTR_WIDTH-1:0] ptr_next;
    logic [PTR_WIDTH-1:0] gray_next;
    logic                 load;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        wq_bin = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            wq_bin[i] = ^(rq2 >> i);
        end
    end

    assign ptr_next       = r_ptr + PTR_WIDTH'(1);
    assign gray_next      = ptr_next ^ (ptr_next >> 1);
    assign r_addr         = r_ptr[PTR_WIDTH-2:0];
    assign r_empty        = (gray_r_ptr == rq2);
    assign r_level        = wq_bin - r_ptr;
    assign r_almost_empty = (r_level <= PTR_WIDTH'(AE_THRESH));
    assign load           = !r_empty && (!r_valid || r_ready);

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rq1        <= '0;
            rq2        <= '0;
            r_ptr      <= '0;
            gray_r_ptr <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            rq1 <= w_gray_ptr;
            rq2 <= rq1;
            if (load) begin
                r_data     <= mem_rdata;
                r_valid    <= 1'b1;
                r_ptr      <= ptr_next;
                gray_r_ptr <= gray_next;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
